// File: rtl/ball_motion_ctrl.sv
// Per-frame bouncing-ball motion controller for a 640x480 display.
// Advances the ball on each synchronised vblank rising edge, reflecting at the screen edges.
module ball_motion_ctrl #(
  parameter int HPIXELS    = 640,
  parameter int VPIXELS    = 480,
  parameter int BALL_HSIZE = 8,
  parameter int BALL_VSIZE = 8,
  parameter int H_INIT     = 310,
  parameter int V_INIT     = 230,
  parameter int POS_W      = 11,
  parameter int SPD_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vblank,
  input  logic [SPD_W-1:0] speed,
  input  logic             pause,
  input  logic             step,
  output logic [POS_W-1:0] ball_h,
  output logic [POS_W-1:0] ball_v,
  output logic             h_dir,
  output logic             v_dir,
  output logic             bounce_h,
  output logic             bounce_v,
  output logic             upd_done,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {IDLE, LATCH, UPD_H, UPD_V} state_t;
  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   ext_t;

  localparam ext_t H_LIM  = ext_t'(HPIXELS);
  localparam ext_t V_LIM  = ext_t'(VPIXELS);
  localparam ext_t H_SIZE = ext_t'(BALL_HSIZE);
  localparam ext_t V_SIZE = ext_t'(BALL_VSIZE);

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  pos_t             ball_h_q, ball_h_d;
  pos_t             ball_v_q, ball_v_d;
  logic             h_dir_q, h_dir_d;
  logic             v_dir_q, v_dir_d;
  logic             bounce_h_q, bounce_h_d;
  logic             bounce_v_q, bounce_v_d;
  logic             upd_done_q, upd_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             step_armed_q, step_armed_d;

  logic fe;
  logic spd_zero;
  ext_t spd_ext;
  pos_t spd_pos;
  logic h_right_hit, h_left_hit, v_down_hit, v_up_hit;

  assign fe       = sync_q[1] & ~sync_q[2];
  assign spd_zero = (spd_q == '0);
  assign spd_ext  = ext_t'(spd_q);
  assign spd_pos  = pos_t'(spd_q);

  // Edge tests use one extra bit so the far-edge sum can never wrap.
  assign h_right_hit = (ext_t'(ball_h_q) + H_SIZE + spd_ext) >= H_LIM;
  assign h_left_hit  = ext_t'(ball_h_q) < spd_ext;
  assign v_down_hit  = (ext_t'(ball_v_q) + V_SIZE + spd_ext) >= V_LIM;
  assign v_up_hit    = ext_t'(ball_v_q) < spd_ext;

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[1:0], vblank};
    spd_d        = spd_q;
    ball_h_d     = ball_h_q;
    ball_v_d     = ball_v_q;
    h_dir_d      = h_dir_q;
    v_dir_d      = v_dir_q;
    bounce_h_d   = 1'b0;
    bounce_v_d   = 1'b0;
    upd_done_d   = 1'b0;
    frame_cnt_d  = fe ? frame_cnt_q + 16'd1 : frame_cnt_q;
    step_armed_d = step_armed_q;

    if (!pause) begin
      step_armed_d = 1'b0;
    end else if (step) begin
      step_armed_d = 1'b1;
    end else if (state_q == LATCH) begin
      step_armed_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fe && (!pause || step_armed_q)) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        spd_d   = speed;
        state_d = UPD_H;
      end
      UPD_H: begin
        // A reversal frame flips direction without moving on that axis.
        if (!spd_zero) begin
          if (!h_dir_q) begin
            if (h_right_hit) begin
              h_dir_d    = 1'b1;
              bounce_h_d = 1'b1;
            end else begin
              ball_h_d = ball_h_q + spd_pos;
            end
          end else begin
            if (h_left_hit) begin
              h_dir_d    = 1'b0;
              bounce_h_d = 1'b1;
            end else begin
              ball_h_d = ball_h_q - spd_pos;
            end
          end
        end
        state_d = UPD_V;
      end
      UPD_V: begin
        if (!spd_zero) begin
          if (!v_dir_q) begin
            if (v_down_hit) begin
              v_dir_d    = 1'b1;
              bounce_v_d = 1'b1;
            end else begin
              ball_v_d = ball_v_q + spd_pos;
            end
          end else begin
            if (v_up_hit) begin
              v_dir_d    = 1'b0;
              bounce_v_d = 1'b1;
            end else begin
              ball_v_d = ball_v_q - spd_pos;
            end
          end
        end
        upd_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      spd_q        <= '0;
      ball_h_q     <= pos_t'(H_INIT);
      ball_v_q     <= pos_t'(V_INIT);
      h_dir_q      <= 1'b0;
      v_dir_q      <= 1'b0;
      bounce_h_q   <= 1'b0;
      bounce_v_q   <= 1'b0;
      upd_done_q   <= 1'b0;
      frame_cnt_q  <= '0;
      step_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      spd_q        <= spd_d;
      ball_h_q     <= ball_h_d;
      ball_v_q     <= ball_v_d;
      h_dir_q      <= h_dir_d;
      v_dir_q      <= v_dir_d;
      bounce_h_q   <= bounce_h_d;
      bounce_v_q   <= bounce_v_d;
      upd_done_q   <= upd_done_d;
      frame_cnt_q  <= frame_cnt_d;
      step_armed_q <= step_armed_d;
    end
  end

  assign ball_h    = ball_h_q;
  assign ball_v    = ball_v_q;
  assign h_dir     = h_dir_q;
  assign v_dir     = v_dir_q;
  assign bounce_h  = bounce_h_q;
  assign bounce_v  = bounce_v_q;
  assign upd_done  = upd_done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: frames push expected results,
// a monitor pops and compares on every upd_done pulse.
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic [3:0]  speed;
  logic        pause;
  logic        step;
  logic [10:0] ball_h;
  logic [10:0] ball_v;
  logic        h_dir;
  logic        v_dir;
  logic        bounce_h;
  logic        bounce_v;
  logic        upd_done;
  logic [15:0] frame_cnt;

  ball_motion_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .vblank    (vblank),
    .speed     (speed),
    .pause     (pause),
    .step      (step),
    .ball_h    (ball_h),
    .ball_v    (ball_v),
    .h_dir     (h_dir),
    .v_dir     (v_dir),
    .bounce_h  (bounce_h),
    .bounce_v  (bounce_v),
    .upd_done  (upd_done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    bit hd;
    bit vd;
    bit bh;
    bit bv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails  = 0;

  int m_h, m_v, m_frames;
  bit m_hd, m_vd, m_armed;
  bit prev_bh;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference motion for one axis, in plain integer arithmetic.
  task automatic model_axis(inout int pos, inout bit dir, output bit bnc,
                            input int spd, input int size, input int lim);
    bnc = 1'b0;
    if (spd != 0) begin
      if (!dir) begin
        if (pos + size + spd >= lim) begin dir = 1'b1; bnc = 1'b1; end
        else pos = pos + spd;
      end else begin
        if (pos < spd) begin dir = 1'b0; bnc = 1'b1; end
        else pos = pos - spd;
      end
    end
  endtask

  task automatic model_reset();
    m_h = 310; m_v = 230; m_hd = 1'b0; m_vd = 1'b0;
    m_frames = 0; m_armed = 1'b0;
  endtask

  // One vblank pulse; speed switches to spd_late one cycle after LATCH.
  task automatic applyStimulus(input logic [3:0] spd, input logic [3:0] spd_late);
    exp_t e;
    bit   bh, bv;
    @(negedge clk);
    speed  = spd;
    vblank = 1'b1;
    m_frames++;
    if (!pause || m_armed) begin
      m_armed = 1'b0;
      model_axis(m_h, m_hd, bh, int'(spd), 8, 640);
      model_axis(m_v, m_vd, bv, int'(spd), 8, 480);
      e.h = m_h; e.v = m_v; e.hd = m_hd; e.vd = m_vd; e.bh = bh; e.bv = bv;
      exp_q.push_back(e);
    end
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
    speed = spd_late;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulseStep();
    @(negedge clk);
    step = 1'b1;
    if (pause) m_armed = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic setPause(input logic v);
    @(negedge clk);
    pause = v;
    if (!v) m_armed = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (upd_done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected upd_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sb ball_h", int'(ball_h), mon_e.h);
          checkOutput("sb ball_v", int'(ball_v), mon_e.v);
          checkOutput("sb h_dir", int'(h_dir), int'(mon_e.hd));
          checkOutput("sb v_dir", int'(v_dir), int'(mon_e.vd));
          checkOutput("sb bounce_h", int'(prev_bh), int'(mon_e.bh));
          checkOutput("sb bounce_v", int'(bounce_v), int'(mon_e.bv));
        end
      end
      prev_bh = bounce_h;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; vblank = 1'b0; speed = 4'd0; pause = 1'b0; step = 1'b0;
    prev_bh = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("reset ball_h", int'(ball_h), 310);
    checkOutput("reset ball_v", int'(ball_v), 230);
    checkOutput("reset h_dir", int'(h_dir), 0);
    checkOutput("reset v_dir", int'(v_dir), 0);
    checkOutput("reset upd_done", int'(upd_done), 0);
    checkOutput("reset frame_cnt", int'(frame_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(4'd4, 4'd4);
    checkOutput("first ball_h", int'(ball_h), 314);
    checkOutput("first ball_v", int'(ball_v), 234);
    checkOutput("first frame_cnt", int'(frame_cnt), 1);

    applyStimulus(4'd2, 4'd2);
    for (int j = 1; j <= 78; j++) begin
      applyStimulus(4'd4, 4'd4);
      if (j == 59) begin
        checkOutput("bottom bounce ball_v", int'(ball_v), 468);
        checkOutput("bottom bounce v_dir", int'(v_dir), 1);
      end
    end
    checkOutput("pre-right ball_h", int'(ball_h), 628);
    checkOutput("pre-right h_dir", int'(h_dir), 0);
    applyStimulus(4'd4, 4'd4);
    checkOutput("right bounce ball_h", int'(ball_h), 628);
    checkOutput("right bounce h_dir", int'(h_dir), 1);
    applyStimulus(4'd4, 4'd4);
    checkOutput("after right ball_h", int'(ball_h), 624);

    for (int j = 0; j < 41; j++) applyStimulus(4'd15, 4'd15);
    checkOutput("left run ball_h", int'(ball_h), 9);
    applyStimulus(4'd6, 4'd6);
    checkOutput("near left ball_h", int'(ball_h), 3);
    applyStimulus(4'd4, 4'd4);
    checkOutput("left bounce ball_h", int'(ball_h), 3);
    checkOutput("left bounce h_dir", int'(h_dir), 0);
    applyStimulus(4'd4, 4'd4);
    checkOutput("after left ball_h", int'(ball_h), 7);

    applyStimulus(4'd4, 4'd15);
    checkOutput("late speed ball_h", int'(ball_h), 11);
    applyStimulus(4'd15, 4'd15);
    checkOutput("speed15 ball_h", int'(ball_h), 26);
    applyStimulus(4'd0, 4'd0);
    checkOutput("speed0 ball_h", int'(ball_h), 26);

    setPause(1'b1);
    repeat (3) applyStimulus(4'd4, 4'd4);
    checkOutput("paused ball_h", int'(ball_h), 26);
    checkOutput("paused frame_cnt", int'(frame_cnt), m_frames);
    pulseStep();
    repeat (2) applyStimulus(4'd4, 4'd4);
    checkOutput("step ball_h", int'(ball_h), 30);
    setPause(1'b0);
    pulseStep();
    setPause(1'b1);
    applyStimulus(4'd4, 4'd4);
    checkOutput("unpaused step ball_h", int'(ball_h), 30);
    checkOutput("unpaused step frame_cnt", int'(frame_cnt), m_frames);
    setPause(1'b0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", exp_q.size(), 0);

    // Reset lands while the FSM sits in UPD_V, after ball_h has already moved.
    @(negedge clk);
    speed = 4'd4; vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset ball_h", int'(ball_h), 310);
    checkOutput("midreset ball_v", int'(ball_v), 230);
    checkOutput("midreset h_dir", int'(h_dir), 0);
    checkOutput("midreset v_dir", int'(v_dir), 0);
    checkOutput("midreset frame_cnt", int'(frame_cnt), 0);
    repeat (3) @(negedge clk);
    checkOutput("midreset upd_done", int'(upd_done), 0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    applyStimulus(4'd4, 4'd4);
    checkOutput("post reset ball_h", int'(ball_h), 314);
    checkOutput("post reset frame_cnt", int'(frame_cnt), 1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("final scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
